// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit                                                          |
// | RV32 load/store unit: alignment and legality checks, byte-lane bus       |
// | mapping, load extraction/extension, bus timeout and flush handling.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter value of the last ACCESS cycle allowed before a timeout.
  localparam logic [7:0] c_TO_LAST = (TIMEOUT <= 1)   ? 8'd0   :
                                     (TIMEOUT >= 256) ? 8'd255 : 8'(TIMEOUT - 1);
  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_MISAL = 2'b01;
  localparam logic [1:0] c_CAUSE_TMO   = 2'b10;
  localparam logic [1:0] c_CAUSE_ILL   = 2'b11;

  state_t      r_state, w_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic [31:0] r_data;
  logic [1:0]  r_cause;
  logic        r_squash;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_access;
  logic        w_pulse;
  logic [31:0] w_shift;
  logic [31:0] w_load_data;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready && !flush;
  assign w_access   = (r_state == S_ACCESS);
  assign w_timeout  = w_access && !mem_ack && (r_cnt == c_TO_LAST);

  assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // Bring the addressed lane down to bit 0, then extend per width/sign.
  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    w_load_data = w_shift;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_data = {24'd0, w_shift[7:0]};
      3'b101:  w_load_data = {16'd0, w_shift[15:0]};
      default: w_load_data = w_shift;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (w_illegal || w_misalign) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ack || w_timeout)
          w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rd     <= 5'd0;
      r_cnt    <= 8'd0;
      r_data   <= 32'd0;
      r_cause  <= c_CAUSE_NONE;
      r_squash <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rd     <= req_rd;
        r_cnt    <= 8'd0;
        r_data   <= 32'd0;
        r_squash <= 1'b0;
        if (w_illegal)
          r_cause <= c_CAUSE_ILL;
        else if (w_misalign)
          r_cause <= c_CAUSE_MISAL;
        else
          r_cause <= c_CAUSE_NONE;
      end
      if (w_access) begin
        // A flush mid-access lets the bus finish but silences the completion.
        if (flush)
          r_squash <= 1'b1;
        if (mem_ack)
          r_data <= r_store ? 32'd0 : w_load_data;
        else if (w_timeout)
          r_cause <= c_CAUSE_TMO;
        if (r_cnt != 8'hFF)
          r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign mem_req  = w_access;
  assign mem_we   = w_access && r_store;
  assign mem_addr = w_access ? {r_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    mem_wstrb = 4'b0000;
    mem_wdata = 32'd0;
    if (w_access && r_store) begin
      case (r_funct3[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << r_addr[1:0];
          mem_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 4'b0011 << r_addr[1:0];
          mem_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = r_wdata;
        end
      endcase
    end
  end

  assign w_pulse    = (r_state == S_RESP) && !r_squash && !flush;
  assign resp_valid = w_pulse && (r_cause == c_CAUSE_NONE);
  assign exc_valid  = w_pulse && (r_cause != c_CAUSE_NONE);
  assign resp_data  = resp_valid ? r_data : 32'd0;
  assign resp_rd    = (resp_valid && !r_store) ? r_rd : 5'd0;
  assign exc_cause  = exc_valid ? r_cause : c_CAUSE_NONE;
  assign exc_addr   = exc_valid ? r_addr : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit                                                       |
// | Directed self-checking bench for load_store_unit (TIMEOUT=4).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int n_total = 0;
  int n_bad   = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents a request in the current (IDLE) cycle; it is accepted at the next edge.
  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  task automatic accept();
    tick();
    req_valid = 1'b0;
  endtask

  // Legal load with an immediate ack; returns with the RESP cycle current.
  task automatic zero_wait_load(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rdata);
    drive_req(1'b0, f3, a, 32'd0, 5'd9);
    accept();
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  int n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_pulses", {30'd0, resp_valid, exc_valid}, 32'd0);
    check("rst_outs", resp_data | exc_addr | 32'(exc_cause) | 32'(resp_rd), 32'd0);
    rst = 1'b0;

    // LB at byte 3, sign-extended
    drive_req(1'b0, 3'b000, 32'h1003, 32'd0, 5'd5);
    check("lb_ready", 32'(req_ready), 32'd1);
    accept();
    check("lb_memreq", 32'(mem_req), 32'd1);
    check("lb_addr", mem_addr, 32'h1000);
    check("lb_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    check("lb_no_resp_yet", 32'(resp_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80AABBCC;
    tick();
    mem_ack = 1'b0;
    check("lb_resp_valid", 32'(resp_valid), 32'd1);
    check("lb_resp_data", resp_data, 32'hFFFFFF80);
    check("lb_resp_rd", 32'(resp_rd), 32'd5);
    check("lb_memreq_off", 32'(mem_req), 32'd0);
    check("lb_no_exc", 32'(exc_valid), 32'd0);
    tick();
    check("lb_idle_resp", 32'(resp_valid), 32'd0);
    check("lb_idle_data", resp_data, 32'd0);
    check("lb_idle_ready", 32'(req_ready), 32'd1);

    // SH at upper half
    drive_req(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd7);
    accept();
    check("sh_strb", 32'(mem_wstrb), 32'hC);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    check("sh_we", 32'(mem_we), 32'd1);
    check("sh_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_resp_valid", 32'(resp_valid), 32'd1);
    check("sh_resp_rd", 32'(resp_rd), 32'd0);
    check("sh_resp_data", resp_data, 32'd0);
    tick();

    // SB at byte 1
    drive_req(1'b1, 3'b000, 32'h4001, 32'h1234ABCD, 5'd0);
    accept();
    check("sb_strb", 32'(mem_wstrb), 32'h2);
    check("sb_wdata", mem_wdata, 32'hCDCDCDCD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Misaligned LW
    drive_req(1'b0, 3'b010, 32'h3001, 32'd0, 5'd3);
    accept();
    check("lwmis_memreq", 32'(mem_req), 32'd0);
    check("lwmis_exc", 32'(exc_valid), 32'd1);
    check("lwmis_cause", 32'(exc_cause), 32'd1);
    check("lwmis_addr", exc_addr, 32'h3001);
    check("lwmis_no_resp", 32'(resp_valid), 32'd0);
    tick();
    check("lwmis_clear", exc_addr | 32'(exc_cause) | 32'(exc_valid), 32'd0);

    // Illegal funct3 011 beats misalignment
    drive_req(1'b0, 3'b011, 32'h3001, 32'd0, 5'd3);
    accept();
    check("ill011_cause", 32'(exc_cause), 32'd3);
    check("ill011_memreq", 32'(mem_req), 32'd0);
    tick();
    // Store with unsigned code is illegal
    drive_req(1'b1, 3'b100, 32'h3000, 32'd0, 5'd0);
    accept();
    check("ill_sbu_cause", 32'(exc_cause), 32'd3);
    tick();

    // Timeout: no ack
    drive_req(1'b0, 3'b010, 32'h5000, 32'd0, 5'd4);
    accept();
    n = 0;
    while (mem_req && n < 10) begin
      n++;
      tick();
    end
    check("tmo_req_cycles", 32'(n), 32'd4);
    check("tmo_exc", 32'(exc_valid), 32'd1);
    check("tmo_cause", 32'(exc_cause), 32'd2);
    check("tmo_addr", exc_addr, 32'h5000);
    tick();

    // Ack on the 4th ACCESS cycle wins over timeout
    drive_req(1'b0, 3'b010, 32'h5004, 32'd0, 5'd6);
    accept();
    tick(); tick(); tick();
    check("tmo_edge_memreq", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    check("tmo_edge_resp", 32'(resp_valid), 32'd1);
    check("tmo_edge_exc", 32'(exc_valid), 32'd0);
    check("tmo_edge_data", resp_data, 32'hDEADBEEF);
    tick();

    // Unsigned and signed halfword loads from upper half
    zero_wait_load(3'b101, 32'h6002, 32'h80011234);
    check("lhu_data", resp_data, 32'h00008001);
    tick();
    zero_wait_load(3'b001, 32'h6002, 32'h80011234);
    check("lh_data", resp_data, 32'hFFFF8001);
    tick();

    // Flush during a 3-cycle LHU access
    drive_req(1'b0, 3'b101, 32'h6002, 32'd0, 5'd8);
    accept();
    flush = 1'b1;
    check("fl_memreq1", 32'(mem_req), 32'd1);
    tick();
    flush = 1'b0;
    check("fl_memreq2", 32'(mem_req), 32'd1);
    tick();
    check("fl_memreq3", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h80011234;
    tick();
    mem_ack = 1'b0;
    check("fl_no_resp", {30'd0, resp_valid, exc_valid}, 32'd0);
    tick();
    check("fl_ready", 32'(req_ready), 32'd1);

    // Flush in RESP suppresses that cycle's pulse
    zero_wait_load(3'b000, 32'h1003, 32'h80AABBCC);
    flush = 1'b1;
    #1;
    check("flresp_no_resp", 32'(resp_valid), 32'd0);
    check("flresp_data", resp_data, 32'd0);
    tick();
    flush = 1'b0;

    // Request with flush in IDLE is dropped
    drive_req(1'b0, 3'b010, 32'h7000, 32'd0, 5'd1);
    flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("fl_idle_memreq", 32'(mem_req), 32'd0);
    check("fl_idle_ready", 32'(req_ready), 32'd1);

    // Reset in mid-ACCESS, late ack ignored
    drive_req(1'b0, 3'b010, 32'h7000, 32'd0, 5'd2);
    accept();
    check("rstacc_memreq_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstacc_memreq", 32'(mem_req), 32'd0);
    check("rstacc_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    check("rstacc_late_ack", {30'd0, resp_valid, exc_valid}, 32'd0);
    check("rstacc_still_idle", 32'(mem_req), 32'd0);
    tick();
    check("rstacc_quiet", {30'd0, resp_valid, exc_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
